// File: rtl/pipeline_pkg.sv
// Shared constants and lane functions for pipeline_n and its testbench.
// The lane functions work on MAX_W-wide vectors; callers zero-extend and slice to W.
package pipeline_pkg;

  localparam int unsigned MIN_DEPTH = 2;
  localparam int unsigned MAX_DEPTH = 16;
  localparam int unsigned MAX_W     = 64;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Packed as {and_ab, and_cd, or_ab, xor_cd}, each MAX_W bits.
  function automatic logic [4*MAX_W-1:0] stage1_terms(input logic [MAX_W-1:0] a,
                                                      input logic [MAX_W-1:0] b,
                                                      input logic [MAX_W-1:0] c,
                                                      input logic [MAX_W-1:0] d);
    return {a & b, c & d, a | b, c ^ d};
  endfunction

  // Packed as {x, y}, each MAX_W bits.
  function automatic logic [2*MAX_W-1:0] stage2_result(input logic [4*MAX_W-1:0] terms);
    logic [MAX_W-1:0] and_ab, and_cd, or_ab, xor_cd;
    {and_ab, and_cd, or_ab, xor_cd} = terms;
    return {and_ab | and_cd, or_ab & ~xor_cd};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage: a valid bit plus a 4W-bit data register.
// Load wins over clear; data is only written on load.
module pipe_slot #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           clear_i,
  input  logic [4*W-1:0] data_i,
  output logic           valid_o,
  output logic [4*W-1:0] data_o
);

  logic           valid_q;
  logic [4*W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_n.sv
// DEPTH-stage valid/ready logic pipeline with bubble collapsing: x=(a&b)|(c&d), y=(a|b)&~(c^d).
// Optional synchronous flush port when PIPE_FLUSH_EN is defined.
module pipeline_n
  import pipeline_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef PIPE_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 a,
  input  logic [W-1:0]                 b,
  input  logic [W-1:0]                 c,
  input  logic [W-1:0]                 d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 x,
  output logic [W-1:0]                 y,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $fatal(1, "pipeline_n: DEPTH must be within 2..16");
  end
  if (W < 1 || W > MAX_W) begin : g_bad_width
    $fatal(1, "pipeline_n: W must be within 1..64");
  end

  logic flush_act;
`ifdef PIPE_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  logic [DEPTH-1:0] v, adv, load, clr;
  logic [4*W-1:0]   slot_d [DEPTH];
  logic [4*W-1:0]   slot_q [DEPTH];
  logic             chain_ready;

  // Walk from the output back to the input; a stage may move if the one after it is
  // empty or is itself moving, which is what lets bubbles collapse.
  always_comb begin : p_adv
    logic down_ok;
    down_ok = out_ready && !flush_act;
    adv     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]  = v[k] && down_ok;
      down_ok = !v[k] || down_ok;
    end
    chain_ready = down_ok;
  end

  assign in_ready  = chain_ready && !flush_act;
  assign out_valid = v[DEPTH-1] && !flush_act;
  assign load      = {adv[DEPTH-2:0] & {(DEPTH-1){!flush_act}}, in_valid && in_ready};
  assign clr       = adv | {DEPTH{flush_act}};

  logic [4*MAX_W-1:0] s1_full;
  logic [2*MAX_W-1:0] s2_full;

  assign s1_full = stage1_terms(MAX_W'(a), MAX_W'(b), MAX_W'(c), MAX_W'(d));
  assign s2_full = stage2_result({MAX_W'(slot_q[0][3*W +: W]), MAX_W'(slot_q[0][2*W +: W]),
                                  MAX_W'(slot_q[0][W +: W]), MAX_W'(slot_q[0][0 +: W])});

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    if (k == 0) begin : g_terms
      assign slot_d[k] = {s1_full[3*MAX_W +: W], s1_full[2*MAX_W +: W],
                          s1_full[MAX_W +: W], s1_full[0 +: W]};
    end else if (k == 1) begin : g_result
      assign slot_d[k] = {{(2*W){1'b0}}, s2_full[MAX_W +: W], s2_full[0 +: W]};
    end else begin : g_pass
      assign slot_d[k] = {{(2*W){1'b0}}, slot_q[k-1][2*W-1:0]};
    end

    pipe_slot #(
      .W (W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .clear_i (clr[k]),
      .data_i  (slot_d[k]),
      .valid_o (v[k]),
      .data_o  (slot_q[k])
    );
  end

  assign x = slot_q[DEPTH-1][W +: W];
  assign y = slot_q[DEPTH-1][0 +: W];

  // Upper halves of result/pass stages and the lane padding carry nothing.
  logic unused_bits;
  always_comb begin
    unused_bits = ^s1_full ^ ^s2_full;
    for (int k = 1; k < DEPTH; k++) begin
      unused_bits = unused_bits ^ ^slot_q[k][4*W-1:2*W];
    end
  end

  logic            push, pop;
  logic [OccW-1:0] occ_q, occ_d;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush_act) begin
      occ_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_n.sv
// Directed self-checking bench for pipeline_n: a W=1/DEPTH=2 and a W=4/DEPTH=4 instance.
// Flush scenario is compiled in only when PIPE_FLUSH_EN is defined.
module tb_pipeline_n;

  logic       clk = 1'b0;
  logic       rst;

  logic       iv2, ir2, ov2, or2;
  logic [0:0] a2, b2, c2, d2, x2, y2;
  logic [1:0] occ2;

  logic       iv4, ir4, ov4, or4;
  logic [3:0] a4, b4, c4, d4, x4, y4;
  logic [2:0] occ4;

`ifdef PIPE_FLUSH_EN
  logic       fl2 = 1'b0;
  logic       fl4 = 1'b0;
`endif

  int checks;
  int failures;

  always #5 clk = ~clk;

  pipeline_n #(.W(1), .DEPTH(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_FLUSH_EN
    .flush     (fl2),
`endif
    .in_valid  (iv2),
    .in_ready  (ir2),
    .a         (a2),
    .b         (b2),
    .c         (c2),
    .d         (d2),
    .out_valid (ov2),
    .out_ready (or2),
    .x         (x2),
    .y         (y2),
    .occupancy (occ2)
  );

  pipeline_n #(.W(4), .DEPTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_FLUSH_EN
    .flush     (fl4),
`endif
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .c         (c4),
    .d         (d4),
    .out_valid (ov4),
    .out_ready (or4),
    .x         (x4),
    .y         (y4),
    .occupancy (occ4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv2 = 1'b0; or2 = 1'b0; a2 = 1'b0; b2 = 1'b0; c2 = 1'b0; d2 = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; c4 = '0; d4 = '0;
    repeat (2) tick();
    rst = 1'b0;
    iv2 = 1'b1; a2 = 1'b1; b2 = 1'b1; c2 = 1'b1; d2 = 1'b1;
    tick();
    iv2 = 1'b0;
    tick();
    checks++;
    if (ov2 !== 1'b1) begin failures++; $display("FAIL rst_prefill_valid: got %b want 1", ov2); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ov2, x2, y2} !== 3'b000) begin
      failures++; $display("FAIL rst_outputs2: got %b want 000", {ov2, x2, y2});
    end
    checks++;
    if (occ2 !== 2'd0) begin failures++; $display("FAIL rst_occ2: got %0d want 0", occ2); end
    checks++;
    if (ir2 !== 1'b1) begin failures++; $display("FAIL rst_in_ready2: got %b want 1", ir2); end
    checks++;
    if ({ov4, x4, y4, occ4, ir4} !== 13'b0_0000_0000_000_1) begin
      failures++; $display("FAIL rst_dut4: got %b want 0000000000001", {ov4, x4, y4, occ4, ir4});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({ov2, occ2} !== 3'b000) begin
      failures++; $display("FAIL rst_no_residue: got %b want 000", {ov2, occ2});
    end
  endtask

  task automatic test_single_bit();
    logic [3:0] vec [4];
    logic [1:0] exp [4];
    vec = '{4'b1111, 4'b0101, 4'b1100, 4'b1011};
    exp = '{2'b11, 2'b00, 2'b11, 2'b11};
    or2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        iv2 = 1'b1;
        {a2, b2, c2, d2} = vec[i];
      end else begin
        iv2 = 1'b0;
      end
      #1;
      checks++;
      if (ir2 !== 1'b1) begin failures++; $display("FAIL sb_in_ready[%0d]: got %b want 1", i, ir2); end
      if (i >= 2) begin
        checks++;
        if ({ov2, x2, y2} !== {1'b1, exp[i-2]}) begin
          failures++;
          $display("FAIL sb_result[%0d]: got %b want %b", i - 2, {ov2, x2, y2}, {1'b1, exp[i-2]});
        end
      end
      if (i == 3) begin
        checks++;
        if (occ2 !== 2'd2) begin failures++; $display("FAIL sb_occ: got %0d want 2", occ2); end
      end
      tick();
    end
    checks++;
    if ({ov2, occ2} !== 3'b000) begin
      failures++; $display("FAIL sb_drained: got %b want 000", {ov2, occ2});
    end
  endtask

  task automatic test_wide();
    logic exp_v;
    or4 = 1'b1;
    iv4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b0110; d4 = 4'b0011;
    #1;
    checks++;
    if (ir4 !== 1'b1) begin failures++; $display("FAIL wide_in_ready: got %b want 1", ir4); end
    tick();
    iv4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      exp_v = (k == 4);
      checks++;
      if (ov4 !== exp_v) begin
        failures++; $display("FAIL wide_latency[%0d]: got %b want %b", k, ov4, exp_v);
      end
    end
    checks++;
    if ({x4, y4} !== 8'b1010_1010) begin
      failures++; $display("FAIL wide_xy: got %b want 10101010", {x4, y4});
    end
    tick();
    checks++;
    if (ov4 !== 1'b0) begin failures++; $display("FAIL wide_consumed: got %b want 0", ov4); end
  endtask

  task automatic test_backpressure();
    int nxt;
    int acc;
    logic [3:0] got [$];
    logic [3:0] exp_x;
    nxt = 1;
    acc = 0;
    or4 = 1'b0;
    b4 = 4'hF; c4 = 4'h0; d4 = 4'h0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      iv4 = (nxt <= 6);
      a4 = 4'(nxt);
      #1;
      if (iv4 && ir4) begin acc++; nxt++; end
      tick();
    end
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    checks++;
    if ({occ4, ir4} !== {3'd4, 1'b0}) begin
      failures++; $display("FAIL bp_full: got occ=%0d rdy=%b want occ=4 rdy=0", occ4, ir4);
    end
    checks++;
    if ({ov4, x4, y4} !== {1'b1, 4'h1, 4'hF}) begin
      failures++; $display("FAIL bp_held_out: got %h want 11f", {ov4, x4, y4});
    end
    or4 = 1'b1;
    for (int cyc = 0; cyc < 20 && got.size() < 6; cyc++) begin
      iv4 = (nxt <= 6);
      a4 = 4'(nxt);
      #1;
      if (iv4 && ir4) begin acc++; nxt++; end
      if (ov4 && or4) got.push_back(x4);
      tick();
    end
    iv4 = 1'b0;
    checks++;
    if (acc !== 6 || got.size() !== 6) begin
      failures++; $display("FAIL bp_counts: got acc=%0d out=%0d want 6/6", acc, got.size());
    end
    for (int i = 0; i < 6; i++) begin
      exp_x = 4'(i + 1);
      checks++;
      if (i >= got.size()) begin
        failures++; $display("FAIL bp_order[%0d]: got none want %h", i, exp_x);
      end else if (got[i] !== exp_x) begin
        failures++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp_x);
      end
    end
    checks++;
    if ({ov4, occ4} !== 4'b0000) begin
      failures++; $display("FAIL bp_drained: got %b want 0000", {ov4, occ4});
    end
  endtask

  task automatic test_bubble();
    or4 = 1'b0;
    b4 = 4'hF; c4 = 4'h0; d4 = 4'h0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      iv4 = (cyc == 0 || cyc == 2);
      a4 = (cyc == 0) ? 4'h9 : 4'h6;
      #1;
      tick();
    end
    iv4 = 1'b0;
    #1;
    checks++;
    if ({occ4, ir4} !== {3'd2, 1'b1}) begin
      failures++; $display("FAIL bub_packed: got occ=%0d rdy=%b want occ=2 rdy=1", occ4, ir4);
    end
    checks++;
    if ({ov4, x4} !== {1'b1, 4'h9}) begin
      failures++; $display("FAIL bub_head: got %h want 19", {ov4, x4});
    end
    or4 = 1'b1;
    tick();
    checks++;
    if ({ov4, x4} !== {1'b1, 4'h6}) begin
      failures++; $display("FAIL bub_second: got %h want 16", {ov4, x4});
    end
    tick();
    checks++;
    if ({ov4, occ4} !== 4'b0000) begin
      failures++; $display("FAIL bub_empty: got %b want 0000", {ov4, occ4});
    end
  endtask

`ifdef PIPE_FLUSH_EN
  task automatic test_flush();
    int seen;
    seen = 0;
    or4 = 1'b0;
    b4 = 4'hF; c4 = 4'h0; d4 = 4'h0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      iv4 = 1'b1;
      a4 = 4'(cyc + 1);
      tick();
    end
    a4 = 4'h7;
    #1;
    checks++;
    if (occ4 !== 3'd4) begin failures++; $display("FAIL fl_full: got %0d want 4", occ4); end
    fl4 = 1'b1;
    #1;
    checks++;
    if ({ov4, ir4} !== 2'b00) begin
      failures++; $display("FAIL fl_during: got %b want 00", {ov4, ir4});
    end
    tick();
    fl4 = 1'b0;
    iv4 = 1'b0;
    #1;
    checks++;
    if ({ov4, occ4} !== 4'b0000) begin
      failures++; $display("FAIL fl_after: got %b want 0000", {ov4, occ4});
    end
    or4 = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (ov4) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL fl_no_stale: got %0d want 0", seen); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_bit();
    test_wide();
    test_backpressure();
    test_bubble();
`ifdef PIPE_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_n.md
Name: pipeline_n

Overview:
- Parametrised successor of the fixed two-stage 4-input/2-output logic pipeline.
- W-bit bitwise lanes; depth set by DEPTH.
- Adds a valid/ready handshake with bubble-collapsing backpressure and an occupancy count.
- Sits between a producer and a consumer that may stall, in place of the fixed-depth, always-advancing version.

Parameters:
- W, 1, bit width of every data input and output (lanes are independent, bitwise).
- DEPTH, 2, number of register stages, legal range 2..16. Elaborating outside this range is a fatal error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b, c, d hold a valid operand set.
- in_ready  output  1  pipeline accepts an operand set this cycle.
- a, b, c, d  input  W  operands.
- out_valid  output  1  x and y hold a valid result.
- out_ready  input  1  consumer accepts a result this cycle.
- x  output  W  (a&b)|(c&d).
- y  output  W  (a|b)&~(c^d).
- occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset, asynchronous: all stage valid bits clear and all stage data clears to 0. While rst is high: out_valid=0, x=0, y=0, occupancy=0, in_ready=1 (combinational).
- Stage 1 registers four W-bit terms: a&b, c&d, a|b, c^d.
- Stage 2 registers the results: x = and_ab | and_cd, y = or_ab & ~xor_cd.
- Stages 3..DEPTH are pass-through registers. x and y come straight from the last stage's registers.
- Transfer occurs in: in_valid&&in_ready. Transfer occurs out: out_valid&&out_ready.
- adv[DEPTH] = v[DEPTH] && out_ready.
- adv[k] = v[k] && (!v[k+1] || adv[k+1]).
- in_ready = !v[1] || adv[1]. This is a combinational chain with no registered skid.
- On each edge, stage k+1 loads from stage k when adv[k]. A stage that empties without being refilled clears its valid bit; its data is held, and is don't-care.
- Bubbles collapse: a downstream stall does not block upstream stages that are empty.
- Latency with no stall: an operand accepted at edge n appears at the output after edge n+DEPTH-1, so out_valid is visible in the following cycle. There is no stall while out_ready=1.
- Throughput is 1 set per cycle when out_ready is held at 1.
- Full (all DEPTH valid, out_ready=0): in_ready=0 and every register holds. out_valid, x and y stay stable until consumed.
- Simultaneous push and pop when full: accepted. Occupancy is unchanged.
- occupancy is registered, updated as +1 on push-only, −1 on pop-only, unchanged otherwise. It never exceeds DEPTH and never wraps.
- in_valid=1 while in_ready=0: input is ignored and nothing is captured.
- Reset mid-stream: all in-flight data is discarded immediately. No partial result is emitted after rst deasserts.

Optional Feature:
- Macro: PIPE_FLUSH_EN.
- When defined, adds port flush (input, 1), synchronous, active-high.
- While flush is asserted, every valid bit clears on the next edge and occupancy goes to 0.
- in_ready is forced to 0 during the flush cycle, so no input is captured.
- out_valid is forced to 0 combinationally while flush is high.
- Data registers are not cleared.
- When not defined: no flush port and no flush logic. Behaviour is exactly as above.

Decomposition:
- Package pipeline_pkg holds:
  - constants MIN_DEPTH=2 and MAX_DEPTH=16.
  - function occ_width(depth) returning $clog2(depth+1).
  - W-generic functions stage1_terms and stage2_result via parametrised struct-free bit vectors; the same functions are used by the scoreboard.
- One sub-module, pipe_slot: one valid bit plus a W*4-bit data register, with load/clear enables and asynchronous reset.
- Instantiate pipe_slot DEPTH times with a generate loop. Stages 2..DEPTH use only the low 2W bits.

Test Plan:
- Reset/idle, W=1, DEPTH=2: assert rst mid-cycle -> out_valid, x, y and occupancy go to 0 immediately; in_ready=1.
- Single-bit vectors, W=1, DEPTH=2, out_ready=1: a=b=c=d=1 -> x=1, y=1 after two edges. Then a=0, b=1, c=0, d=1 -> x=0, y=0. Then a=1, b=1, c=0, d=0 -> x=1, y=1. Then a=1, b=0, c=1, d=1 -> x=1, y=1.
- Wide lanes, W=4, DEPTH=4: a=1100, b=1010, c=0110, d=0011 -> x=1010, y=1010, out_valid asserted 4 cycles after acceptance.
- Backpressure, W=4, DEPTH=4: hold out_ready=0 and stream 6 sets -> exactly 4 accepted, occupancy=4, in_ready=0, output stable. Release out_ready -> results drain in order with none lost or duplicated, and the remaining 2 sets are accepted.
- Bubble collapse, DEPTH=4: send 2 sets with 1-cycle gaps, then stall -> both packed at stages 3 and 4, occupancy=2, in_ready=1.
- PIPE_FLUSH_EN defined, pipeline full: pulse flush for 1 cycle -> next cycle occupancy=0, out_valid=0. The previous results never appear at the output.
